// File: rtl/decode_stage_if.sv
// IF/ID word, write-back port and ID/EX outputs of the decode stage.
// master drives the fetch/write-back side; slave is the decode stage itself.
interface decode_stage_if;
  logic        ifIdValid;
  logic [4:0]  opCode;
  logic [2:0]  Rs;
  logic [2:0]  Rd;
  logic [4:0]  SHMNT;
  logic        isImmediate;
  logic [31:0] nextInstructionAddress;
  logic        flush;
  logic        wbEnable;
  logic [2:0]  wbAddr;
  logic [15:0] wbData;
  logic        stall;
  logic        idExValid;
  logic [4:0]  idExOpCode;
  logic [2:0]  idExRs;
  logic [2:0]  idExRd;
  logic [4:0]  idExShmnt;
  logic [31:0] idExPc;
  logic [15:0] idExSrc1;
  logic [15:0] idExSrc2;
  logic [15:0] idExImm;
  logic        idExRegWrite;
  logic        idExMemRead;
  logic        idExMemWrite;
  logic        idExBranch;
  logic        idExUseImm;

  modport master (
    output ifIdValid, opCode, Rs, Rd, SHMNT, isImmediate, nextInstructionAddress,
           flush, wbEnable, wbAddr, wbData,
    input  stall, idExValid, idExOpCode, idExRs, idExRd, idExShmnt, idExPc,
           idExSrc1, idExSrc2, idExImm, idExRegWrite, idExMemRead, idExMemWrite,
           idExBranch, idExUseImm
  );

  modport slave (
    input  ifIdValid, opCode, Rs, Rd, SHMNT, isImmediate, nextInstructionAddress,
           flush, wbEnable, wbAddr, wbData,
    output stall, idExValid, idExOpCode, idExRs, idExRd, idExShmnt, idExPc,
           idExSrc1, idExSrc2, idExImm, idExRegWrite, idExMemRead, idExMemWrite,
           idExBranch, idExUseImm
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: 8x16 register file with write-back bypass, control decode,
// two-word immediate handling and load-use hazard stall into the ID/EX register.
module decode_stage (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned PC_W   = 32;

  typedef enum logic {DECODE, IMM_WAIT} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rd;
    logic [SH_W-1:0]   shmnt;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } inst_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    inst_t             inst;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
    logic              use_imm;
  } id_ex_t;

  state_t            state, state_nxt;
  inst_t             pend, pend_nxt;
  id_ex_t            id_ex, id_ex_nxt;
  inst_t             cur;
  logic [DATA_W-1:0] rf [REG_N];
  logic [DATA_W-1:0] raw_word;
  logic              hazard;

  function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    if (op != '0) begin
      case (op[4:3])
        2'b01: c.reg_write = 1'b1;
        2'b10: begin
          if (op[2]) begin
            c.mem_write = 1'b1;
          end else begin
            c.mem_read  = 1'b1;
            c.reg_write = 1'b1;
          end
        end
        2'b11:   c.branch = 1'b1;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // Current IF/ID word with operands read through the write-back bypass.
  always_comb begin
    cur       = '0;
    cur.op    = bus.opCode;
    cur.rs    = bus.Rs;
    cur.rd    = bus.Rd;
    cur.shmnt = bus.SHMNT;
    cur.pc    = bus.nextInstructionAddress;
    cur.src1  = (bus.wbEnable && (bus.wbAddr == bus.Rs)) ? bus.wbData : rf[bus.Rs];
    cur.src2  = (bus.wbEnable && (bus.wbAddr == bus.Rd)) ? bus.wbData : rf[bus.Rd];
    raw_word  = {bus.opCode, bus.Rs, bus.Rd, bus.SHMNT};
  end

  // Load-use hazard; flush and reset both override it.
  always_comb begin
    hazard = 1'b0;
    if (rst && !bus.flush && (state == DECODE) && bus.ifIdValid &&
        (bus.opCode[4:3] != 2'b00) && id_ex.valid && id_ex.ctrl.mem_read &&
        ((id_ex.inst.rd == bus.Rs) || (id_ex.inst.rd == bus.Rd))) begin
      hazard = 1'b1;
    end
  end

  assign bus.stall = hazard;

  // Next-state and ID/EX next value; bubbles keep the data fields untouched.
  always_comb begin
    state_nxt         = state;
    pend_nxt          = pend;
    id_ex_nxt         = id_ex;
    id_ex_nxt.valid   = 1'b0;
    id_ex_nxt.ctrl    = '0;
    id_ex_nxt.use_imm = 1'b0;
    if (bus.flush) begin
      state_nxt = DECODE;
      pend_nxt  = '0;
    end else if (!hazard) begin
      case (state)
        DECODE: begin
          if (bus.ifIdValid) begin
            if (bus.isImmediate) begin
              pend_nxt  = cur;
              state_nxt = IMM_WAIT;
            end else begin
              id_ex_nxt.valid = 1'b1;
              id_ex_nxt.inst  = cur;
              id_ex_nxt.imm   = '0;
              id_ex_nxt.ctrl  = decode_ctrl(cur.op);
            end
          end
        end
        IMM_WAIT: begin
          if (bus.ifIdValid) begin
            id_ex_nxt.valid   = 1'b1;
            id_ex_nxt.inst    = pend;
            id_ex_nxt.imm     = raw_word;
            id_ex_nxt.ctrl    = decode_ctrl(pend.op);
            id_ex_nxt.use_imm = 1'b1;
            state_nxt         = DECODE;
          end
        end
        default: state_nxt = DECODE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DECODE;
      pend  <= '0;
      id_ex <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      id_ex <= id_ex_nxt;
    end
  end

  // Register file; write-back is independent of stall, flush and bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(REG_N); i++) rf[i] <= '0;
    end else if (bus.wbEnable) begin
      rf[bus.wbAddr] <= bus.wbData;
    end
  end

  assign bus.idExValid    = id_ex.valid;
  assign bus.idExOpCode   = id_ex.inst.op;
  assign bus.idExRs       = id_ex.inst.rs;
  assign bus.idExRd       = id_ex.inst.rd;
  assign bus.idExShmnt    = id_ex.inst.shmnt;
  assign bus.idExPc       = id_ex.inst.pc;
  assign bus.idExSrc1     = id_ex.inst.src1;
  assign bus.idExSrc2     = id_ex.inst.src2;
  assign bus.idExImm      = id_ex.imm;
  assign bus.idExRegWrite = id_ex.ctrl.reg_write;
  assign bus.idExMemRead  = id_ex.ctrl.mem_read;
  assign bus.idExMemWrite = id_ex.ctrl.mem_write;
  assign bus.idExBranch   = id_ex.ctrl.branch;
  assign bus.idExUseImm   = id_ex.use_imm;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, reset-in-IMM_WAIT sequence,
// and random traffic checked against a cycle-level behavioural model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model state: register file, waiting-for-immediate flag, pending word, expected ID/EX.
  logic [15:0] m_rf [8];
  bit          m_wait;
  logic [15:0] p_word, p_s1, p_s2;
  logic [31:0] p_pc;
  bit          e_valid;
  logic [4:0]  e_ctrl;   // {RegWrite, MemRead, MemWrite, Branch, UseImm}
  logic [15:0] e_word, e_s1, e_s2, e_imm;
  logic [31:0] e_pc;

  typedef struct {
    bit          v;
    logic [15:0] word;
    bit          im;
    logic [31:0] pc;
    bit          fl;
    bit          we;
    logic [2:0]  wa;
    logic [15:0] wd;
    bit          x_stall;
    bit          x_valid;
    logic [4:0]  x_ctrl;
    logic [15:0] x_s1, x_s2, x_imm;
    logic [31:0] x_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrl_of(input logic [4:0] op);
    if (op == 5'd0) return 4'b0000;
    case (op[4:3])
      2'b01:   return 4'b1000;
      2'b10:   return op[2] ? 4'b0010 : 4'b1100;
      2'b11:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_wait = 0; p_word = 0; p_s1 = 0; p_s2 = 0; p_pc = 0;
    e_valid = 0; e_ctrl = 0; e_word = 0; e_s1 = 0; e_s2 = 0; e_imm = 0; e_pc = 0;
  endtask

  task automatic check_outputs();
    check("idex_valid", 32'(bus.idExValid), 32'(e_valid));
    check("idex_ctrl", 32'({bus.idExRegWrite, bus.idExMemRead, bus.idExMemWrite,
                            bus.idExBranch, bus.idExUseImm}), 32'(e_ctrl));
    if (e_valid) begin
      check("idex_fields", 32'({bus.idExOpCode, bus.idExRs, bus.idExRd, bus.idExShmnt}), 32'(e_word));
      check("idex_src1", 32'(bus.idExSrc1), 32'(e_s1));
      check("idex_src2", 32'(bus.idExSrc2), 32'(e_s2));
      check("idex_imm", 32'(bus.idExImm), 32'(e_imm));
      check("idex_pc", bus.idExPc, e_pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_ctrl"}, 32'({bus.idExValid, bus.idExRegWrite, bus.idExMemRead,
          bus.idExMemWrite, bus.idExBranch, bus.idExUseImm}), 32'h0);
    check({tag, "_fields"}, 32'({bus.idExOpCode, bus.idExRs, bus.idExRd, bus.idExShmnt}), 32'h0);
    check({tag, "_pc"}, bus.idExPc, 32'h0);
    check({tag, "_src"}, {bus.idExSrc1, bus.idExSrc2}, 32'h0);
    check({tag, "_imm"}, 32'(bus.idExImm), 32'h0);
    check({tag, "_stall"}, 32'(bus.stall), 32'h0);
  endtask

  // One clock: drive at negedge, check stall mid-cycle, advance model, check ID/EX after posedge.
  task automatic apply(input bit v, input logic [15:0] w, input bit im, input logic [31:0] pc,
                       input bit fl, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       output logic st);
    logic [2:0]  rs, rd;
    logic [15:0] s1, s2;
    bit          e_stall;
    @(negedge clk);
    bus.ifIdValid = v;
    {bus.opCode, bus.Rs, bus.Rd, bus.SHMNT} = w;
    bus.isImmediate = im;
    bus.nextInstructionAddress = pc;
    bus.flush = fl;
    bus.wbEnable = we;
    bus.wbAddr = wa;
    bus.wbData = wd;
    #1;
    rs = w[10:8];
    rd = w[7:5];
    s1 = (we && wa == rs) ? wd : m_rf[rs];
    s2 = (we && wa == rd) ? wd : m_rf[rd];
    e_stall = !fl && !m_wait && v && (w[15:14] != 2'b00) && e_valid && e_ctrl[3] &&
              (e_word[7:5] == rs || e_word[7:5] == rd);
    st = bus.stall;
    check("stall", 32'(st), 32'(e_stall));
    e_valid = 0;
    e_ctrl  = 0;
    if (fl) begin
      m_wait = 0;
    end else if (!e_stall) begin
      if (!m_wait) begin
        if (v && !im) begin
          e_valid = 1; e_word = w; e_s1 = s1; e_s2 = s2; e_pc = pc; e_imm = 0;
          e_ctrl = {ctrl_of(w[15:11]), 1'b0};
        end else if (v) begin
          p_word = w; p_s1 = s1; p_s2 = s2; p_pc = pc; m_wait = 1;
        end
      end else if (v) begin
        e_valid = 1; e_word = p_word; e_s1 = p_s1; e_s2 = p_s2; e_pc = p_pc; e_imm = w;
        e_ctrl = {ctrl_of(p_word[15:11]), 1'b1};
        m_wait = 0;
      end
    end
    if (we) m_rf[wa] = wd;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       st;
    logic [4:0] ops [6];
    logic [4:0] op;
    bus.ifIdValid = 0; bus.opCode = 0; bus.Rs = 0; bus.Rd = 0; bus.SHMNT = 0;
    bus.isImmediate = 0; bus.nextInstructionAddress = 0; bus.flush = 0;
    bus.wbEnable = 0; bus.wbAddr = 0; bus.wbData = 0;
    model_reset();

    //           v  word    im pc     fl we wa wd       stall valid ctrl     s1       s2       imm      pc
    tbl.push_back('{0, 16'h0000, 0, 32'h00, 0, 1, 3'd1, 16'h0005, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{0, 16'h0000, 0, 32'h00, 0, 1, 3'd2, 16'h0007, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'h4140, 0, 32'h10, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b10000, 16'h0005, 16'h0007, 16'h0, 32'h10});
    tbl.push_back('{1, 16'h4320, 0, 32'h11, 0, 1, 3'd3, 16'hBEEF, 0, 1, 5'b10000, 16'hBEEF, 16'h0005, 16'h0, 32'h11});
    tbl.push_back('{1, 16'h4940, 1, 32'h20, 0, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'h1234, 0, 32'h21, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b10001, 16'h0005, 16'h0007, 16'h1234, 32'h20});
    tbl.push_back('{1, 16'h8080, 0, 32'h30, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b11000, 16'h0, 16'h0, 16'h0, 32'h30});
    tbl.push_back('{1, 16'h4400, 0, 32'h31, 0, 0, 3'd0, 16'h0000, 1, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'h4400, 0, 32'h31, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b10000, 16'h0, 16'h0, 16'h0, 32'h31});
    tbl.push_back('{1, 16'h4140, 1, 32'h40, 0, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'h8080, 0, 32'h41, 1, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'h4220, 0, 32'h50, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b10000, 16'h0007, 16'h0005, 16'h0, 32'h50});
    tbl.push_back('{1, 16'h8060, 0, 32'h60, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b11000, 16'h0, 16'hBEEF, 16'h0, 32'h60});
    tbl.push_back('{1, 16'h4300, 0, 32'h61, 1, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'hC140, 1, 32'h70, 0, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{0, 16'h0000, 0, 32'h00, 0, 0, 3'd0, 16'h0000, 0, 0, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h0});
    tbl.push_back('{1, 16'hABCD, 0, 32'h71, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b00011, 16'h0005, 16'h0007, 16'hABCD, 32'h70});
    tbl.push_back('{1, 16'h0000, 0, 32'h80, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b00000, 16'h0, 16'h0, 16'h0, 32'h80});
    tbl.push_back('{1, 16'hA140, 0, 32'h81, 0, 0, 3'd0, 16'h0000, 0, 1, 5'b00100, 16'h0005, 16'h0007, 16'h0, 32'h81});

    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].word, tbl[i].im, tbl[i].pc, tbl[i].fl, tbl[i].we,
            tbl[i].wa, tbl[i].wd, st);
      check($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].x_stall));
      check($sformatf("tbl%0d_valid", i), 32'(bus.idExValid), 32'(tbl[i].x_valid));
      check($sformatf("tbl%0d_ctrl", i), 32'({bus.idExRegWrite, bus.idExMemRead,
            bus.idExMemWrite, bus.idExBranch, bus.idExUseImm}), 32'(tbl[i].x_ctrl));
      if (tbl[i].x_valid) begin
        check($sformatf("tbl%0d_src", i), {bus.idExSrc1, bus.idExSrc2}, {tbl[i].x_s1, tbl[i].x_s2});
        check($sformatf("tbl%0d_imm", i), 32'(bus.idExImm), 32'(tbl[i].x_imm));
        check($sformatf("tbl%0d_pc", i), bus.idExPc, tbl[i].x_pc);
      end
    end

    // Asynchronous reset while waiting for an immediate word.
    apply(1, 16'h4140, 0, 32'h90, 0, 0, 3'd0, 16'h0, st);
    apply(1, 16'h4140, 1, 32'h91, 0, 0, 3'd0, 16'h0, st);
    bus.ifIdValid = 0;
    bus.wbEnable  = 0;
    bus.flush     = 0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    apply(1, 16'h4140, 0, 32'hA0, 0, 0, 3'd0, 16'h0, st);
    check("post_rst_valid", 32'({bus.idExValid, bus.idExUseImm}), 32'b10);
    check("post_rst_regs", {bus.idExSrc1, bus.idExSrc2}, 32'h0);

    // Randomised traffic against the model.
    ops = '{5'b00000, 5'b01000, 5'b01101, 5'b10000, 5'b10100, 5'b11000};
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 5)];
      apply($urandom_range(0, 9) < 8, {op, 11'($urandom)}, $urandom_range(0, 4) == 0,
            $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            3'($urandom), 16'($urandom), st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
